// File: rtl/rstb_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rstb_seq_pkg
// Purpose  : Shared types and elaboration-time helpers for the RSTB reset
//            sequencer (state encoding, parameter legality check).
// Contents : state_t        - FSM state enum (IDLE, HOLD, RELEASE)
//            params_legal() - constant function validating sequencer params
// Revision : 1.0 - initial release
// ============================================================================
package rstb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // True when the parameter set can be built: at least one domain, non-zero
  // hold and gap, and a counter wide enough for the larger of the two.
  function automatic bit params_legal(input int n_dom, input int hold_cyc,
                                      input int gap_cyc, input int cw);
    int mx;
    mx = (hold_cyc > gap_cyc) ? hold_cyc : gap_cyc;
    return (n_dom >= 1) && (hold_cyc >= 1) && (gap_cyc >= 1) && (cw >= 1) &&
           ((cw >= 31) || (mx < (1 << cw)));
  endfunction

endpackage : rstb_seq_pkg
`default_nettype wire

// File: rtl/rstb_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : rstb_seq_timer
// Purpose  : CW-bit up-counter with clear, enable and terminal-count compare.
//            Returns to 0 on the cycle it is enabled at terminal count, so it
//            never wraps. Shared by the HOLD and GAP phases of the sequencer.
// Ports    : clk     in  clock
//            rst     in  synchronous active-high reset
//            clr     in  synchronous clear (priority over enable)
//            en      in  count enable
//            term    in  terminal count value
//            at_term out count currently equals term
// Revision : 1.0 - initial release
// ============================================================================
module rstb_seq_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] term,
  output logic          at_term
);

  logic [CW-1:0] count;

  assign at_term = (count == term);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      if (at_term) begin
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule : rstb_seq_timer
`default_nettype wire

// File: rtl/rstb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rstb_sequencer
// Purpose  : Drives active-low reset pins of N_DOM flop-bank domains. Holds
//            all domains low for HOLD_CYC cycles, then releases them one at a
//            time, GAP_CYC cycles apart, in ascending index order. Every
//            output is a flop.
// Ports    : clk      in  clock
//            rst      in  synchronous active-high reset (starts a sequence)
//            pwr_ok   in  power-good; low forces all domains into reset
//            req      in  single-cycle reset request
//            rstb_out out active-low reset per domain (bit i -> domain i)
//            busy     out high whenever the FSM is not IDLE
//            done     out one-cycle pulse on the last domain release
// Revision : 1.0 - initial release
// ============================================================================
module rstb_sequencer
  import rstb_seq_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int HOLD_CYC = 8,
  parameter int GAP_CYC  = 2,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_ok,
  input  logic             req,
  output logic [N_DOM-1:0] rstb_out,
  output logic             busy,
  output logic             done
);

  localparam int               IW        = $clog2(N_DOM) + 1;
  localparam logic [CW-1:0]    HOLD_TERM = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0]    GAP_TERM  = CW'(GAP_CYC - 1);
  localparam logic [N_DOM-1:0] ONE       = N_DOM'(1);
  localparam logic [IW-1:0]    LAST_IDX  = IW'(N_DOM - 1);

  if (!params_legal(N_DOM, HOLD_CYC, GAP_CYC, CW)) begin : g_param_check
    $error("rstb_sequencer: illegal parameter set");
  end

  state_t        state;
  logic [IW-1:0] idx;
  logic          abort;
  logic          tmr_clr;
  logic          tmr_at_term;
  logic [CW-1:0] tmr_term;

  // Power loss outranks a request, but both force the same restart, so a
  // single abort term covers them.
  assign abort    = !pwr_ok || req;
  // The timer only runs in HOLD/RELEASE; any restart re-arms it from 0,
  // which is what guarantees the full HOLD_CYC low width.
  assign tmr_clr  = abort || (state == IDLE);
  assign tmr_term = (state == HOLD) ? HOLD_TERM : GAP_TERM;

  rstb_seq_timer #(
    .CW (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (1'b1),
    .term    (tmr_term),
    .at_term (tmr_at_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      idx      <= '0;
      rstb_out <= '0;
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= HOLD;
        idx      <= '0;
        rstb_out <= '0;
        busy     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            rstb_out <= '1;
            busy     <= 1'b0;
          end
          HOLD: begin
            if (tmr_at_term) begin
              if (N_DOM == 1) begin
                state    <= IDLE;
                rstb_out <= '1;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                state    <= RELEASE;
                rstb_out <= ONE;
                idx      <= IW'(1);
              end
            end
          end
          RELEASE: begin
            if (tmr_at_term) begin
              // Bits below idx are already 1, so OR-ing keeps ascending order.
              rstb_out <= rstb_out | (ONE << idx);
              if (idx == LAST_IDX) begin
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx <= idx + IW'(1);
              end
            end
          end
          default: begin
            state    <= HOLD;
            idx      <= '0;
            rstb_out <= '0;
            busy     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule : rstb_sequencer
`default_nettype wire

// File: tb/tb_rstb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rstb_sequencer
// Purpose  : Self-checking bench for rstb_sequencer. Drives a 4-domain
//            instance and a degenerate 1-domain/1-cycle-hold instance from
//            shared stimulus and compares both against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rstb_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwr_ok = 1'b1;
  logic       req = 1'b0;
  logic [3:0] rstb_out;
  logic       busy;
  logic       done;
  logic [0:0] rstb_out1;
  logic       busy1;
  logic       done1;

  int tests = 0;
  int fails = 0;

  // Model state: cycles since the latest sequence start, and whether a
  // sequence is still in progress.
  int t0 = 0;
  bit act0 = 1'b1;
  int t1 = 0;
  bit act1 = 1'b1;
  logic [3:0] er0, er1;
  logic eb0, ed0, eb1, ed1;

  always #5 clk = ~clk;

  rstb_sequencer #(
    .N_DOM(4), .HOLD_CYC(8), .GAP_CYC(2), .CW(8)
  ) dut (
    .clk(clk), .rst(rst), .pwr_ok(pwr_ok), .req(req),
    .rstb_out(rstb_out), .busy(busy), .done(done)
  );

  rstb_sequencer #(
    .N_DOM(1), .HOLD_CYC(1), .GAP_CYC(1), .CW(8)
  ) dut1 (
    .clk(clk), .rst(rst), .pwr_ok(pwr_ok), .req(req),
    .rstb_out(rstb_out1), .busy(busy1), .done(done1)
  );

  // Timeline model: a restart event sets t=0; domain i is released once
  // t >= h + i*g; done fires exactly when the last domain is released.
  task automatic model_edge(input int n, input int h, input int g,
                            input logic r, input logic p, input logic q,
                            inout int t, inout bit act,
                            output logic [3:0] er, output logic eb,
                            output logic ed);
    int  last;
    bit  restart;
    last    = h + (n - 1) * g;
    restart = r || !p || q;
    er = '0;
    eb = 1'b0;
    ed = 1'b0;
    if (restart) begin
      t   = 0;
      act = 1'b1;
    end else if (act) begin
      t++;
    end
    if (act) begin
      for (int i = 0; i < n; i++) if (t >= h + i * g) er[i] = 1'b1;
      ed = (t == last);
      eb = (t < last);
      if (t >= last) act = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) er[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    tests++;
    assert (rstb_out === er0) else begin
      fails++;
      $error("FAIL rstb4 t=%0t got %b exp %b", $time, rstb_out, er0);
    end
    tests++;
    assert (busy === eb0) else begin
      fails++;
      $error("FAIL busy4 t=%0t got %b exp %b", $time, busy, eb0);
    end
    tests++;
    assert (done === ed0) else begin
      fails++;
      $error("FAIL done4 t=%0t got %b exp %b", $time, done, ed0);
    end
    tests++;
    assert (rstb_out1[0] === er1[0]) else begin
      fails++;
      $error("FAIL rstb1 t=%0t got %b exp %b", $time, rstb_out1[0], er1[0]);
    end
    tests++;
    assert (busy1 === eb1) else begin
      fails++;
      $error("FAIL busy1 t=%0t got %b exp %b", $time, busy1, eb1);
    end
    tests++;
    assert (done1 === ed1) else begin
      fails++;
      $error("FAIL done1 t=%0t got %b exp %b", $time, done1, ed1);
    end
  endtask

  // One clock edge with the given inputs, then model update and checks.
  task automatic step(input logic r, input logic p, input logic q);
    rst    = r;
    pwr_ok = p;
    req    = q;
    @(posedge clk);
    model_edge(4, 8, 2, r, p, q, t0, act0, er0, eb0, ed0);
    model_edge(1, 1, 1, r, p, q, t1, act1, er1, eb1, ed1);
    #1;
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic expect_rstb(input string tag, input logic [3:0] exp);
    tests++;
    assert (rstb_out === exp) else begin
      fails++;
      $error("FAIL %s got %b exp %b", tag, rstb_out, exp);
    end
  endtask

  initial begin
    int pwr_low_left;
    logic r, p, q;

    // Reset, including reset and request together on the last reset edge.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    expect_rstb("reset_value", 4'b0000);
    idle_steps(20);
    expect_rstb("after_reset_seq", 4'b1111);

    // Request in IDLE: low for 7 edges after the request, bit 0 on the 8th.
    step(1'b0, 1'b1, 1'b1);
    expect_rstb("req_assert", 4'b0000);
    idle_steps(7);
    expect_rstb("hold_edge7", 4'b0000);
    idle_steps(1);
    expect_rstb("bit0_edge8", 4'b0001);
    idle_steps(2);
    expect_rstb("bit1_edge10", 4'b0011);

    // Mid-release re-request.
    step(1'b0, 1'b1, 1'b1);
    expect_rstb("rereq_assert", 4'b0000);
    idle_steps(16);

    // Power drop during HOLD.
    step(1'b0, 1'b1, 1'b1);
    idle_steps(3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
    idle_steps(16);

    // Power drop during RELEASE.
    step(1'b0, 1'b1, 1'b1);
    idle_steps(9);
    step(1'b0, 1'b0, 1'b0);
    idle_steps(16);

    // Request held continuously: stays asserted, no done.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    expect_rstb("req_held", 4'b0000);
    idle_steps(16);

    // Randomized phase.
    pwr_low_left = 0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 19) == 0);
      if (pwr_low_left == 0 && $urandom_range(0, 29) == 0)
        pwr_low_left = $urandom_range(1, 6);
      p = (pwr_low_left == 0);
      if (pwr_low_left > 0) pwr_low_left--;
      step(r, p, q);
    end
    idle_steps(16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_rstb_sequencer
`default_nettype wire
